// File: rtl/comp_sched_pkg.sv
// Shared types and defaults for the complement scheduler.
package comp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  typedef logic client_id_t;

  localparam int unsigned DEFAULT_SETTLE = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational grant with a rotating priority pointer.
module rr_arbiter2
  import comp_sched_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  client_id_t ptr,
  output logic       valid,
  output client_id_t gnt
);

  // A lone requester wins outright; a tie goes to the client named by ptr.
  always_comb begin
    valid = req0 | req1;
    gnt   = 1'b0;
    if (req0 && req1) begin
      gnt = ptr;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/comp_scheduler.sv
// Sequencer and two-client arbiter for a shared ripple two's-complement unit.
// Optional overflow flag output enabled by defining COMP_SCHED_OVF_FLAG_EN.
module comp_scheduler
  import comp_sched_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] op1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic [WIDTH-1:0] comp_a,
  input  logic [WIDTH-1:0] comp_w
`ifdef COMP_SCHED_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned     CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  client_id_t       gnt;
  client_id_t       ptr;
  client_id_t       arb_gnt;
  logic             arb_valid;

  rr_arbiter2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .valid (arb_valid),
    .gnt   (arb_gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; ack and busy decoded from the registered state.
  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        ack0      = (gnt == 1'b0);
        ack1      = (gnt == 1'b1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch, settle countdown, result capture and pointer rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_a <= '0;
      res    <= '0;
      cnt    <= '0;
      gnt    <= 1'b0;
      ptr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            comp_a <= arb_gnt ? op1 : op0;
            gnt    <= arb_gnt;
            cnt    <= CNT_INIT;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res <= comp_w;
          end
        end
        DONE: begin
          ptr <= ~gnt;
        end
        default: ;
      endcase
    end
  end

`ifdef COMP_SCHED_OVF_FLAG_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Flag the one operand whose negation is not representable, captured with res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SETTLE && cnt == '0) begin
      ovf <= (comp_a == MOST_NEG);
    end
  end
`endif

endmodule

// File: doc/comp_scheduler.md
Name: comp_scheduler

Overview:
- Sequencing controller and two-requester arbiter for one shared ripple-carry two's-complement unit (WIDTH-bit, negates its input).
- The complement unit stays outside this block. This block drives its operand, waits a fixed number of settle cycles for the ripple chain, captures the result, and returns it to the granted requester with a one-cycle ack.
- Sits between the two client datapaths and the gate-level complementor.

Parameters:
- WIDTH, 8, operand/result width.
- SETTLE_CYCLES, 4, clock cycles the operand is held on comp_a before comp_w is captured; must be >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  request from client 0; held until ack0.
- op0  input  WIDTH  operand from client 0; valid while req0 is high.
- req1  input  1  request from client 1.
- op1  input  WIDTH  operand from client 1.
- ack0  output  1  one-cycle pulse; res is valid for client 0.
- ack1  output  1  one-cycle pulse; res is valid for client 1.
- res  output  WIDTH  captured complement; holds until the next capture.
- busy  output  1  high in SETTLE and DONE.
- comp_a  output  WIDTH  registered operand to the complement unit.
- comp_w  input  WIDTH  result from the complement unit.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; comp_a=0; res=0; ack0=ack1=0; busy=0; cnt=0; priority pointer=client 0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE, on a clock edge:
  - If req0 or req1 is high, grant one requester.
  - Only one requesting: it wins.
  - Both requesting: the requester named by the priority pointer wins.
  - On grant: comp_a<=granted op, gnt<=winner id, cnt<=SETTLE_CYCLES-1, next state SETTLE.
  - No request: stay in IDLE.
- SETTLE:
  - cnt>0: cnt<=cnt-1.
  - cnt==0: res<=comp_w, next state DONE.
  - comp_a is held constant throughout.
- DONE:
  - ack[gnt]=1 for exactly this cycle (decoded from the registered state).
  - Priority pointer<=the non-granted client.
  - Next state IDLE.
- Latency: request sampled at edge k; ack high in the cycle after edge k+SETTLE_CYCLES. Minimum spacing between acks is SETTLE_CYCLES+2 cycles.
- Operand is sampled only at the grant edge; changes to op during SETTLE are ignored.
- A requester may keep req high after its ack to issue a new request. The new op must be valid in the IDLE cycle that follows.
- Requests arriving during SETTLE/DONE wait; nothing is dropped or queued beyond the level-held req.
- ack0 and ack1 are never high together.
- Arithmetic is modulo 2^WIDTH (handled by the unit): res = (~op + 1) mod 2^WIDTH. 0 maps to 0; 2^(WIDTH-1) maps to itself.
- Reset mid-SETTLE or mid-DONE: the operation is abandoned, no ack is issued, and a requester still holding req is re-granted from IDLE.

Optional Feature:
- Macro: COMP_SCHED_OVF_FLAG_EN.
- Defined: adds output port ovf (1 bit), registered together with res. ovf<=1 when the captured operand equals 2^(WIDTH-1) (negation not representable), otherwise 0. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package comp_sched_pkg:
  - state_t enum {IDLE, SETTLE, DONE}.
  - client_id_t (1 bit).
  - localparam DEFAULT_SETTLE = 4.
- Sub-module rr_arbiter2: combinational two-way grant from req0/req1 and the priority pointer. The pointer register stays in comp_scheduler.

Test Plan:
- Reset, then req0=1, op0=8'h05 (SETTLE_CYCLES=4) -> comp_a=8'h05 after the grant edge; ack0 pulses once, 5 cycles after the sampled edge; res=8'hFB; ack1 stays 0; busy high for 5 cycles.
- req0 and req1 rise together, op0=8'h01, op1=8'h10, both held -> client 0 served first (res=8'hFF with ack0), then client 1 (res=8'hF0 with ack1); service keeps alternating 0,1,0,1 while both are held; acks are spaced 6 cycles apart.
- op0=8'h00 -> res=8'h00. op0=8'h80 -> res=8'h80, and ovf=1 with COMP_SCHED_OVF_FLAG_EN (ovf=0 for 8'h00).
- op1=8'h3C granted, op1 changed to 8'hAA during SETTLE -> res=8'hC4.
- Assert rst for one cycle during SETTLE -> all outputs 0 immediately, no ack for the aborted request; with req0 still held, the next grant runs from scratch and acks normally.
- Unit model with 3-cycle comp_w delay, SETTLE_CYCLES=4 -> results correct. With SETTLE_CYCLES=1 against the same model -> a mismatch is detected, which validates the bench's checker.
